// File: rtl/debug_ocimem_pkg.sv
// Shared types and constants for the OCI debug-memory arbiter.
//   state_t  : arbiter FSM states
//   grant_t  : which requester owns the RAM port (also the fairness token)
//   JDO_*    : field positions inside the 38-bit JTAG data register
package debug_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_JTAG_RD = 2'd1,
        ST_AVS_RD  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_JTAG = 1'b0,
        GNT_AVS  = 1'b1
    } grant_t;

    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_DATA_MSB = 31;
    localparam int JDO_DATA_LSB = 0;
    localparam int DATA_W       = 32;
    localparam int BE_W         = 4;

endpackage

// File: rtl/debug_ocimem_jtag_queue.sv
// JTAG side of the OCI memory arbiter: decodes the sysclk action strobes,
// holds the single-entry pending-operation register, and owns MonAReg and
// MonDReg.
//   clk, reset            : system clock, async active-high reset
//   jdo                   : JTAG data register (already in clk domain)
//   take_action_ocimem_a  : load address, optionally queue a read (jdo[35])
//   take_action_ocimem_b  : queue a full-word write of jdo[31:0] at MonAReg
//   grant_i               : the pending op owns the RAM port this cycle
//   jtag_rd_i             : arbiter is in JTAG_RD; ram_rdata is the read word
//   ram_rdata             : RAM read data
//   pend_o / pend_wr_o    : an op is queued / it is a write
//   wr_data_o             : data for the queued write
//   MonAReg, MonDReg      : JTAG address and data registers
//   jtag_overrun          : sticky, a strobe was dropped because we were busy
module debug_ocimem_jtag_queue
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              grant_i,
    input  logic              jtag_rd_i,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              pend_o,
    output logic              pend_wr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_overrun
);

    logic              pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] areg_q, areg_d;
    logic [DATA_W-1:0] dreg_q, dreg_d;
    logic              ovr_q, ovr_d;
    logic              busy;

    // jdo bits outside the address/data/read-flag fields carry no meaning here.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_RD_BIT-1:DATA_W]};

    // The pending slot frees in the same cycle it is granted, so a strobe
    // landing on the grant cycle is accepted. A strobe of either kind while
    // busy is dropped whole: even a bare address load would retarget the
    // queued op.
    assign busy = (pend_q && !grant_i) || jtag_rd_i;

    always_comb begin
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        wr_data_d = wr_data_q;
        areg_d    = areg_q;
        dreg_d    = dreg_q;
        ovr_d     = ovr_q;

        if (grant_i) begin
            pend_d = 1'b0;
            if (pend_wr_q) begin
                areg_d = areg_q + ADDR_W'(1);
            end
        end

        if (jtag_rd_i) begin
            dreg_d = ram_rdata;
        end

        if (take_action_ocimem_a || take_action_ocimem_b) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                areg_d = jdo[ADDR_W-1:0];
                if (jdo[JDO_RD_BIT]) begin
                    pend_d    = 1'b1;
                    pend_wr_d = 1'b0;
                end
            end else begin
                // Write data is kept apart from MonDReg so a JTAG read that
                // completes while this write waits cannot corrupt it.
                dreg_d    = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                wr_data_d = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                pend_d    = 1'b1;
                pend_wr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            pend_wr_q <= 1'b0;
            wr_data_q <= '0;
            areg_q    <= '0;
            dreg_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            wr_data_q <= wr_data_d;
            areg_q    <= areg_d;
            dreg_q    <= dreg_d;
            ovr_q     <= ovr_d;
        end
    end

    assign pend_o       = pend_q;
    assign pend_wr_o    = pend_wr_q;
    assign wr_data_o    = wr_data_q;
    assign MonAReg      = areg_q;
    assign MonDReg      = dreg_q;
    assign jtag_overrun = ovr_q;

endmodule

// File: rtl/debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug slave and the
// CPU-side Avalon debug memory slave, with round-robin fairness on conflict.
//   clk, reset           : system clock, async active-high reset
//   jdo, take_action_*   : JTAG strobes (see debug_ocimem_jtag_queue)
//   avs_*                : Avalon-MM slave; avs_readdata registered
//   ram_*                : RAM macro port, read data one cycle after address
//   MonAReg, MonDReg     : JTAG address / data registers
//   mon_ready            : no JTAG op queued or in flight
//   jtag_overrun         : sticky dropped-strobe flag
//   dbg_state_o          : current FSM state
// Handshake: a request (avs_read|avs_write) is accepted in the cycle where it
// is high and avs_waitrequest is low; the master must hold it until then.
// Write wins if both read and write are high. Read data returns exactly once
// with avs_readdatavalid, two cycles after acceptance.
module debug_ocimem_arbiter
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [BE_W-1:0]   ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [DATA_W-1:0] MonDReg,
    output logic              mon_ready,
    output logic              jtag_overrun,
    output state_t            dbg_state_o
);

    state_t            state_q, state_d;
    grant_t            last_q, last_d;
    logic              jtag_pend, jtag_pend_wr;
    logic [DATA_W-1:0] jtag_wdata;
    logic              jtag_grant, avs_grant;
    logic              avs_req;
    logic [DATA_W-1:0] readdata_q;
    logic              rdv_q;

    debug_ocimem_jtag_queue #(.ADDR_W(ADDR_W)) u_jtag_queue (
        .clk                  (clk),
        .reset                (reset),
        .jdo                  (jdo),
        .take_action_ocimem_a (take_action_ocimem_a),
        .take_action_ocimem_b (take_action_ocimem_b),
        .grant_i              (jtag_grant),
        .jtag_rd_i            (state_q == ST_JTAG_RD),
        .ram_rdata            (ram_rdata),
        .pend_o               (jtag_pend),
        .pend_wr_o            (jtag_pend_wr),
        .wr_data_o            (jtag_wdata),
        .MonAReg              (MonAReg),
        .MonDReg              (MonDReg),
        .jtag_overrun         (jtag_overrun)
    );

    assign avs_req = avs_read | avs_write;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        jtag_grant = 1'b0;
        avs_grant  = 1'b0;
        ram_addr   = avs_address;
        ram_wren   = 1'b0;
        ram_byteen = avs_byteenable;
        ram_wdata  = avs_writedata;

        case (state_q)
            ST_IDLE: begin
                // On conflict the side that did not win last time goes first.
                if (jtag_pend && (!avs_req || last_q == GNT_AVS)) begin
                    jtag_grant = 1'b1;
                end else if (avs_req) begin
                    avs_grant = 1'b1;
                end

                if (jtag_grant) begin
                    last_d     = GNT_JTAG;
                    ram_addr   = MonAReg;
                    ram_byteen = '1;
                    ram_wdata  = jtag_wdata;
                    ram_wren   = jtag_pend_wr;
                    if (!jtag_pend_wr) begin
                        state_d = ST_JTAG_RD;
                    end
                end else if (avs_grant) begin
                    last_d   = GNT_AVS;
                    ram_wren = avs_write;
                    if (!avs_write) begin
                        state_d = ST_AVS_RD;
                    end
                end
            end
            ST_JTAG_RD: state_d = ST_IDLE;
            ST_AVS_RD:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= GNT_AVS;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rdv_q   <= (state_q == ST_AVS_RD);
            if (state_q == ST_AVS_RD) begin
                readdata_q <= ram_rdata;
            end
        end
    end

    assign avs_waitrequest   = avs_req && !avs_grant;
    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = rdv_q;
    assign mon_ready         = !jtag_pend && (state_q != ST_JTAG_RD);
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
module tb_debug_ocimem_arbiter;
    import debug_ocimem_pkg::*;

    localparam int ADDR_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [JDO_W-1:0]  jdo;
    logic              take_a, take_b;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read, avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_waitrequest;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [3:0]        ram_byteen;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [ADDR_W-1:0] MonAReg;
    logic [31:0]       MonDReg;
    logic              mon_ready;
    logic              jtag_overrun;
    state_t            dbg_state;

    debug_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .jdo                  (jdo),
        .take_action_ocimem_a (take_a),
        .take_action_ocimem_b (take_b),
        .avs_address          (avs_address),
        .avs_read             (avs_read),
        .avs_write            (avs_write),
        .avs_writedata        (avs_writedata),
        .avs_byteenable       (avs_byteenable),
        .avs_waitrequest      (avs_waitrequest),
        .avs_readdata         (avs_readdata),
        .avs_readdatavalid    (avs_readdatavalid),
        .ram_addr             (ram_addr),
        .ram_wren             (ram_wren),
        .ram_byteen           (ram_byteen),
        .ram_wdata            (ram_wdata),
        .ram_rdata            (ram_rdata),
        .MonAReg              (MonAReg),
        .MonDReg              (MonDReg),
        .mon_ready            (mon_ready),
        .jtag_overrun         (jtag_overrun),
        .dbg_state_o          (dbg_state)
    );

    // ---------------- RAM model ----------------
    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'hAAAAAAAA;
            mem[8'h03] <= 32'hCAFE0003;
            mem_init   <= 1'b1;
        end else if (ram_wren) begin
            mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_byteen);
        end
        ram_rdata <= mem[ram_addr];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] mon_e;
    int          mon_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Avalon read acceptances record their cycle; every readdatavalid pops
    // one expected word and must arrive two cycles after acceptance.
    always @(negedge clk) begin
        if (!reset && avs_read && !avs_write && !avs_waitrequest) lat_q.push_back(cyc);
        if (avs_readdatavalid) begin
            if (exp_q.size() == 0 || lat_q.size() == 0) begin
                check("rdv_unexpected", {31'b0, avs_readdatavalid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_g = lat_q.pop_front();
                check("avs_rdata", avs_readdata, mon_e);
                check("avs_rdv_latency", 32'(cyc), 32'(mon_g + 2));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) next_cyc();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        jdo = '0; take_a = 1'b0; take_b = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        sample();
        check("rst_MonAReg", 32'(MonAReg), 32'h0);
        check("rst_MonDReg", MonDReg, 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_rdv", {31'b0, avs_readdatavalid}, 32'd0);
        check("rst_mon_ready", {31'b0, mon_ready}, 32'd1);
        check("rst_overrun", {31'b0, jtag_overrun}, 32'd0);
        check("rst_wren", {31'b0, ram_wren}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // JTAG read of 0x10
        next_cyc(); take_a = 1'b1; jdo = 38'h8_0000_0010;
        sample(); check("t1_ready_strobe", {31'b0, mon_ready}, 32'd1);
        next_cyc(); take_a = 1'b0; jdo = '0;
        sample();
        check("t1_MonAReg", 32'(MonAReg), 32'h10);
        check("t1_ready_pend", {31'b0, mon_ready}, 32'd0);
        check("t1_ram_addr", 32'(ram_addr), 32'h10);
        check("t1_wren", {31'b0, ram_wren}, 32'd0);
        next_cyc(); sample();
        check("t1_state_rd", 32'(dbg_state), 32'(ST_JTAG_RD));
        check("t1_ready_inflight", {31'b0, mon_ready}, 32'd0);
        check("t1_MonDReg_early", MonDReg, 32'h0);
        next_cyc(); sample();
        check("t1_MonDReg", MonDReg, 32'hDEADBEEF);
        check("t1_ready_done", {31'b0, mon_ready}, 32'd1);

        // Address 0xFF without read, then three writes wrapping the address
        next_cyc(); take_a = 1'b1; jdo = 38'h0_0000_00FF;
        next_cyc(); take_a = 1'b0; jdo = '0;
        sample();
        check("t2_MonAReg_ff", 32'(MonAReg), 32'hFF);
        check("t2_ready_noread", {31'b0, mon_ready}, 32'd1);
        next_cyc(); take_b = 1'b1; jdo = 38'h1;
        next_cyc(); jdo = 38'h2;
        sample();
        check("t2_w1_wren", {31'b0, ram_wren}, 32'd1);
        check("t2_w1_addr", 32'(ram_addr), 32'hFF);
        check("t2_w1_data", ram_wdata, 32'h1);
        next_cyc(); jdo = 38'h3;
        sample();
        check("t2_w2_addr", 32'(ram_addr), 32'h00);
        check("t2_w2_data", ram_wdata, 32'h2);
        next_cyc(); take_b = 1'b0; jdo = '0;
        sample();
        check("t2_w3_addr", 32'(ram_addr), 32'h01);
        check("t2_w3_data", ram_wdata, 32'h3);
        next_cyc(); sample();
        check("t2_MonAReg_wrap", 32'(MonAReg), 32'h02);
        check("t2_no_overrun", {31'b0, jtag_overrun}, 32'd0);
        check("t2_mem_ff", mem[8'hFF], 32'h1);
        check("t2_mem_00", mem[8'h00], 32'h2);
        check("t2_mem_01", mem[8'h01], 32'h3);

        // Reset so last_grant is AVS, then conflict JTAG write vs Avalon reads
        next_cyc(); reset = 1'b1;
        repeat (2) next_cyc();
        reset = 1'b0;
        next_cyc(); take_b = 1'b1; jdo = 38'h55;
        next_cyc(); jdo = 38'h66; avs_read = 1'b1; avs_address = 8'h10;
        sample();
        check("t3_jtag_first_wren", {31'b0, ram_wren}, 32'd1);
        check("t3_jtag_first_addr", 32'(ram_addr), 32'h00);
        check("t3_wait_1", {31'b0, avs_waitrequest}, 32'd1);
        next_cyc(); take_b = 1'b0; jdo = '0;
        sample();
        check("t3_avs_turn", {31'b0, avs_waitrequest}, 32'd0);
        check("t3_avs_turn_wren", {31'b0, ram_wren}, 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        next_cyc(); sample();
        check("t3_state_avsrd", 32'(dbg_state), 32'(ST_AVS_RD));
        check("t3_wait_avsrd", {31'b0, avs_waitrequest}, 32'd1);
        next_cyc(); sample();
        check("t3_jtag_again_wren", {31'b0, ram_wren}, 32'd1);
        check("t3_jtag_again_data", ram_wdata, 32'h66);
        check("t3_wait_2", {31'b0, avs_waitrequest}, 32'd1);
        next_cyc(); sample();
        check("t3_avs_again", {31'b0, avs_waitrequest}, 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        next_cyc(); avs_read = 1'b0;
        drain("t3_drain");
        check("t3_mem_00", mem[8'h00], 32'h55);
        check("t3_mem_01", mem[8'h01], 32'h66);

        // Avalon partial write then read-back of the merged word
        next_cyc(); avs_write = 1'b1; avs_address = 8'h20;
        avs_writedata = 32'h12345678; avs_byteenable = 4'b0011;
        sample();
        check("t4_wren", {31'b0, ram_wren}, 32'd1);
        check("t4_wait", {31'b0, avs_waitrequest}, 32'd0);
        check("t4_byteen", 32'(ram_byteen), 32'h3);
        check("t4_addr", 32'(ram_addr), 32'h20);
        next_cyc(); avs_write = 1'b0; avs_read = 1'b1;
        sample();
        check("t4_rd_accept", {31'b0, avs_waitrequest}, 32'd0);
        exp_q.push_back(32'hAAAA5678);
        next_cyc(); avs_read = 1'b0;
        drain("t4_drain");

        // Overrun: second write strobe while the first waits behind AVS_RD
        next_cyc(); avs_read = 1'b1; avs_address = 8'h10; take_b = 1'b1; jdo = 38'h77;
        sample();
        check("t5_avs_grant", {31'b0, avs_waitrequest}, 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        next_cyc(); avs_read = 1'b0; jdo = 38'h88;
        sample();
        check("t5_state_avsrd", 32'(dbg_state), 32'(ST_AVS_RD));
        check("t5_no_ovr_yet", {31'b0, jtag_overrun}, 32'd0);
        next_cyc(); take_b = 1'b0; jdo = '0;
        sample();
        check("t5_overrun", {31'b0, jtag_overrun}, 32'd1);
        check("t5_w_wren", {31'b0, ram_wren}, 32'd1);
        check("t5_w_addr", 32'(ram_addr), 32'h02);
        check("t5_w_data", ram_wdata, 32'h77);
        next_cyc(); sample();
        check("t5_ready", {31'b0, mon_ready}, 32'd1);
        check("t5_no_second", {31'b0, ram_wren}, 32'd0);
        check("t5_MonAReg", 32'(MonAReg), 32'h03);
        drain("t5_drain");
        check("t5_mem_02", mem[8'h02], 32'h77);
        check("t5_mem_03", mem[8'h03], 32'hCAFE0003);

        // Reset asserted during AVS_RD aborts the read
        next_cyc(); avs_read = 1'b1; avs_address = 8'h10;
        sample();
        check("t6_avs_grant", {31'b0, avs_waitrequest}, 32'd0);
        next_cyc(); avs_read = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_rdv", {31'b0, avs_readdatavalid}, 32'd0);
        check("t6_readdata", avs_readdata, 32'h0);
        check("t6_MonAReg", 32'(MonAReg), 32'h0);
        check("t6_MonDReg", MonDReg, 32'h0);
        check("t6_overrun", {31'b0, jtag_overrun}, 32'd0);
        check("t6_mon_ready", {31'b0, mon_ready}, 32'd1);
        check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_wren", {31'b0, ram_wren}, 32'd0);
        lat_q.delete();
        repeat (3) next_cyc();
        reset = 1'b0;
        next_cyc(); next_cyc();
        sample();
        check("t6_rdv_after", {31'b0, avs_readdatavalid}, 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
